proc_controller: RTL and testbench

- Moore FSM control unit for the six-instruction processor.
- Sequences the fetch/decode/execute loop: drives PC clear/increment, the IR load enable (IR_Id), data-memory address and write, register-file read/write addresses and enables, RF write-source mux, and ALU function select.
- Consumes the current IR contents (IRout) as its instruction input; sits between the IR and the datapath.

---
 rtl/ctrl_pkg.sv | 32 +++
 rtl/instr_fields.sv | 23 ++
 rtl/proc_controller.sv | 113 +++++++++++
 tb/tb_proc_controller.sv | 106 ++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, FSM state codes, ALU selects and IR field positions for proc_controller
package ctrl_pkg;
  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;
  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam int OP_LSB      = 12;
  localparam int RA_LSB      = 8;
  localparam int RB_LSB      = 4;
  localparam int RD_LSB      = 0;
  localparam int LD_ADDR_LSB = 4;
  localparam int ST_ADDR_LSB = 0;
endpackage

// File: rtl/instr_fields.sv
// instr_fields: splits an instruction word into opcode, register and data-address fields
module instr_fields
  import ctrl_pkg::*;
#(
  parameter int IW  = 16,
  parameter int DAW = 8,
  parameter int RAW = 4
) (
  input  logic [IW-1:0]  i_ins,
  output opcode_t        o_opcode,
  output logic [RAW-1:0] o_ra,
  output logic [RAW-1:0] o_rb,
  output logic [RAW-1:0] o_rd,
  output logic [DAW-1:0] o_ld_daddr,
  output logic [DAW-1:0] o_st_daddr
);
  assign o_opcode   = opcode_t'(i_ins[OP_LSB +: 4]);
  assign o_ra       = i_ins[RA_LSB +: RAW];
  assign o_rb       = i_ins[RB_LSB +: RAW];
  assign o_rd       = i_ins[RD_LSB +: RAW];
  assign o_ld_daddr = i_ins[LD_ADDR_LSB +: DAW];
  assign o_st_daddr = i_ins[ST_ADDR_LSB +: DAW];
endmodule

// File: rtl/proc_controller.sv
// proc_controller: Moore fetch/decode/execute FSM for the six-instruction processor.
// Define CTRL_ILLEGAL_TRAP_EN to trap opcodes 0110-1111 into HALT with Illegal set.
module proc_controller
  import ctrl_pkg::*;
#(
  parameter int IW  = 16,
  parameter int DAW = 8,
  parameter int RAW = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [IW-1:0]  Ins,
  output logic           PC_clr,
  output logic           PC_up,
  output logic           IR_Id,
  output logic [DAW-1:0] D_Addr,
  output logic           D_wr,
  output logic           RF_s,
  output logic [RAW-1:0] RF_W_addr,
  output logic           RF_W_en,
  output logic [RAW-1:0] RF_Ra_addr,
  output logic [RAW-1:0] RF_Rb_addr,
  output logic [2:0]     ALU_s0,
  output logic [3:0]     OutState,
  output logic           Illegal
);
  state_t         r_state, w_next;
  opcode_t        w_op;
  logic [RAW-1:0] w_ra, w_rb, w_rd;
  logic [DAW-1:0] w_ld_daddr, w_st_daddr;
  logic           w_illegal_op;
  instr_fields #(.IW(IW), .DAW(DAW), .RAW(RAW)) u_fields (
    .i_ins(Ins), .o_opcode(w_op), .o_ra(w_ra), .o_rb(w_rb), .o_rd(w_rd),
    .o_ld_daddr(w_ld_daddr), .o_st_daddr(w_st_daddr)
  );
  assign w_illegal_op = w_op > OP_HALT;
  assign OutState = r_state;
  always_ff @(posedge Clk)
    r_state <= Reset ? S_INIT : w_next;
  always_comb begin
    w_next     = S_INIT;
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_Id      = 1'b0;
    D_Addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = ALU_PASS;
    case (r_state)
      S_INIT: begin
        PC_clr = 1'b1;
        w_next = S_FETCH;
      end
      S_FETCH: begin
        IR_Id  = 1'b1;
        PC_up  = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_op)
          OP_NOOP:  w_next = S_FETCH;
          OP_STORE: w_next = S_STORE;
          OP_LOAD:  w_next = S_LOAD_A;
          OP_ADD:   w_next = S_ADD;
          OP_SUB:   w_next = S_SUB;
          OP_HALT:  w_next = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:  w_next = S_HALT;
`else
          default:  w_next = S_NOOP;
`endif
        endcase
      end
      S_NOOP: w_next = S_FETCH;
      S_LOAD_A, S_LOAD_B: begin
        D_Addr    = w_ld_daddr;
        RF_s      = 1'b1;
        RF_W_addr = w_rd;
        RF_W_en   = r_state == S_LOAD_B;
        w_next    = r_state == S_LOAD_B ? S_FETCH : S_LOAD_B;
      end
      S_STORE: begin
        D_Addr     = w_st_daddr;
        RF_Ra_addr = w_ra;
        D_wr       = 1'b1;
        w_next     = S_FETCH;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = w_ra;
        RF_Rb_addr = w_rb;
        RF_W_addr  = w_rd;
        RF_W_en    = 1'b1;
        ALU_s0     = r_state == S_ADD ? ALU_ADD : ALU_SUB;
        w_next     = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_INIT;
    endcase
  end
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge Clk)
    if (Reset) r_illegal <= 1'b0;
    else if (r_state == S_DECODE && w_illegal_op) r_illegal <= 1'b1;
  assign Illegal = r_illegal && r_state == S_HALT;
`else
  assign Illegal = 1'b0;
`endif
endmodule

// File: tb/tb_proc_controller.sv
// tb_proc_controller: directed checks of every state's outputs, HALT hold and reset recovery
module tb_proc_controller;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Ins;
  logic        PC_clr, PC_up, IR_Id, D_wr, RF_s, RF_W_en, Illegal;
  logic [7:0]  D_Addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState;
  logic [2:0]  ALU_s0;
  int total = 0;
  int bad = 0;
  proc_controller dut (
    .Clk(Clk), .Reset(Reset), .Ins(Ins), .PC_clr(PC_clr), .PC_up(PC_up), .IR_Id(IR_Id),
    .D_Addr(D_Addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .ALU_s0(ALU_s0), .OutState(OutState),
    .Illegal(Illegal)
  );
  always #5 Clk = ~Clk;
  task automatic nxt;
    @(negedge Clk);
  endtask
  task automatic ck(input string tag, input logic [3:0] st, input logic pcc, input logic pcu,
                    input logic ir, input logic [7:0] da, input logic dw, input logic rs,
                    input logic [3:0] wa, input logic we, input logic [3:0] ra,
                    input logic [3:0] rb, input logic [2:0] alu, input logic il);
    logic [33:0] obs, exp;
    obs = {OutState, PC_clr, PC_up, IR_Id, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, Illegal};
    exp = {st, pcc, pcu, ir, da, dw, rs, wa, we, ra, rb, alu, il};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic ck_init(input string tag);
    ck(tag, 4'd0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0);
  endtask
  task automatic ck_fetch(input string tag);
    ck(tag, 4'd1, 0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0);
  endtask
  task automatic ck_decode(input string tag);
    ck(tag, 4'd2, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0);
  endtask
  initial begin
    Reset = 1'b1;
    Ins = 16'h0000;
    nxt; nxt;
    ck_init("reset_hold");
    Reset = 1'b0;
    ck_init("init");
    nxt; ck_fetch("fetch0");
    Ins = 16'h21B3;
    nxt; ck_decode("load_decode");
    nxt; ck("load_a", 4'd4, 0, 0, 0, 8'h1B, 0, 1, 4'h3, 0, 4'h0, 4'h0, 3'd0, 0);
    nxt; ck("load_b", 4'd5, 0, 0, 0, 8'h1B, 0, 1, 4'h3, 1, 4'h0, 4'h0, 3'd0, 0);
    nxt; ck_fetch("load_fetch");
    Ins = 16'h3125;
    nxt; ck_decode("add_decode");
    nxt; ck("add", 4'd7, 0, 0, 0, 8'h00, 0, 0, 4'h5, 1, 4'h1, 4'h2, 3'd1, 0);
    nxt; ck_fetch("add_fetch");
    Ins = 16'h4125;
    nxt; ck_decode("sub_decode");
    nxt; ck("sub", 4'd8, 0, 0, 0, 8'h00, 0, 0, 4'h5, 1, 4'h1, 4'h2, 3'd2, 0);
    nxt; ck_fetch("sub_fetch");
    Ins = 16'h1A44;
    nxt; ck_decode("store_decode");
    nxt; ck("store", 4'd6, 0, 0, 0, 8'h44, 1, 0, 4'h0, 0, 4'hA, 4'h0, 3'd0, 0);
    nxt; ck_fetch("store_fetch");
    Ins = 16'h0000;
    nxt; ck_decode("noop_decode");
    nxt; ck_fetch("noop_fetch");
    Ins = 16'h7000;
    nxt; ck_decode("ill_decode");
    nxt;
`ifdef CTRL_ILLEGAL_TRAP_EN
    ck("ill_halt", 4'd9, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 1);
    nxt; ck("ill_halt_hold", 4'd9, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 1);
`else
    ck("ill_noop", 4'd3, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0);
    nxt; ck_fetch("ill_fetch");
`endif
    Reset = 1'b1;
    nxt; ck_init("ill_reset");
    Reset = 1'b0;
    nxt; ck_fetch("ill_recover");
    Ins = 16'h5000;
    nxt; ck_decode("halt_decode");
    for (int i = 0; i < 20; i++) begin
      nxt; ck($sformatf("halt_%0d", i), 4'd9, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0);
    end
    Reset = 1'b1;
    nxt; ck_init("halt_reset");
    Reset = 1'b0;
    nxt; ck_fetch("halt_recover");
    Ins = 16'h21B3;
    nxt; ck_decode("abort_decode");
    nxt; ck("abort_load_a", 4'd4, 0, 0, 0, 8'h1B, 0, 1, 4'h3, 0, 4'h0, 4'h0, 3'd0, 0);
    Reset = 1'b1;
    nxt; ck_init("abort_no_write");
    Reset = 1'b0;
    nxt; ck_fetch("abort_recover");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
